// File: rtl/namuru_dump_sched_pkg.sv
// Shared types and defaults for the correlator dump scheduler.
// Holds the FSM state encoding and a small wrap-around increment helper.
package namuru_dump_sched_pkg;

  localparam int unsigned NumChDefault = 12;
  localparam int unsigned WordsDefault = 6;
  localparam int unsigned DwDefault    = 16;

  typedef enum logic [1:0] {
    StIdle,
    StSel,
    StCap,
    StOut
  } state_e;

  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/namuru_dump_sched_if.sv
// Accumulator read-mux select/data and outbound word stream of the dump scheduler.
// master = scheduler side, slave = mux plus register/FIFO side.
interface namuru_dump_sched_if
  import namuru_dump_sched_pkg::*;
#(
  parameter int unsigned NUM_CH = NumChDefault,
  parameter int unsigned WORDS  = WordsDefault,
  parameter int unsigned DW     = DwDefault
);
  localparam int unsigned CHW = $clog2(NUM_CH);
  localparam int unsigned WW  = $clog2(WORDS);

  logic [CHW-1:0] sel_ch;
  logic [WW-1:0]  sel_word;
  logic [DW-1:0]  sel_data;
  logic           out_valid;
  logic           out_ready;
  logic [CHW-1:0] out_ch;
  logic [WW-1:0]  out_word;
  logic [DW-1:0]  out_data;
  logic           out_last;

  modport master (
    output sel_ch, sel_word, out_valid, out_ch, out_word, out_data, out_last,
    input  sel_data, out_ready
  );

  modport slave (
    input  sel_ch, sel_word, out_valid, out_ch, out_word, out_data, out_last,
    output sel_data, out_ready
  );

endinterface

// File: rtl/namuru_dump_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
module namuru_dump_sched_rr_arbiter #(
  parameter int unsigned NUM_CH = 12
) (
  input  logic [NUM_CH-1:0]         req_i,
  input  logic [$clog2(NUM_CH)-1:0] ptr_i,
  output logic [$clog2(NUM_CH)-1:0] grant_o,
  output logic                      any_o
);
  localparam int unsigned CHW = $clog2(NUM_CH);

  logic [CHW:0] idx;

  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = {1'b0, ptr_i} + (CHW+1)'(i);
      if (idx >= (CHW+1)'(NUM_CH)) idx = idx - (CHW+1)'(NUM_CH);
      if (!any_o && req_i[idx[CHW-1:0]]) begin
        any_o   = 1'b1;
        grant_o = idx[CHW-1:0];
      end
    end
  end

endmodule

// File: rtl/namuru_dump_sched.sv
// Shares the accumulator read-mux between channels: latches dump requests, grants round-robin,
// reads WORDS words per grant into a valid/ready stream and tracks new-data/overflow status.
module namuru_dump_sched
  import namuru_dump_sched_pkg::*;
#(
  parameter int unsigned NUM_CH = NumChDefault,
  parameter int unsigned WORDS  = WordsDefault,
  parameter int unsigned DW     = DwDefault
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [NUM_CH-1:0]   dump_req_i,
  input  logic                status_clr_i,
  output logic [NUM_CH-1:0]   status_new_o,
  output logic [NUM_CH-1:0]   status_ovf_o,
  output logic                accum_int_o,
  output logic                busy_o,
  namuru_dump_sched_if.master bus
);
  localparam int unsigned CHW = $clog2(NUM_CH);
  localparam int unsigned WW  = $clog2(WORDS);

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] pending_q, pending_d, new_q, new_d, ovf_q, ovf_d, grant_mask;
  logic [CHW-1:0]    ptr_q, ptr_d, sel_ch_q, sel_ch_d, out_ch_q, out_ch_d, grant;
  logic [WW-1:0]     sel_word_q, sel_word_d, out_word_q, out_word_d;
  logic [DW-1:0]     out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d, out_last_q, out_last_d, accum_int_q;
  logic              any_req, grant_fire, word_last;

  namuru_dump_sched_rr_arbiter #(
    .NUM_CH(NUM_CH)
  ) u_arb (
    .req_i  (pending_q),
    .ptr_i  (ptr_q),
    .grant_o(grant),
    .any_o  (any_req)
  );

  assign grant_fire = (state_q == StIdle) && any_req;
  assign word_last  = (sel_word_q == WW'(WORDS - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= StIdle;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = StSel;
      StSel:   state_d = StCap;
      StCap:   state_d = StOut;
      StOut:   if (bus.out_ready) state_d = word_last ? StIdle : StSel;
      default: state_d = StIdle;
    endcase
  end

  // sel_* only move on entry to SEL, so the mux never sees a stray select mid-capture.
  always_comb begin
    ptr_d       = ptr_q;
    sel_ch_d    = sel_ch_q;
    sel_word_d  = sel_word_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;
    out_word_d  = out_word_q;
    out_data_d  = out_data_q;
    grant_mask  = '0;
    if (grant_fire) grant_mask[grant] = 1'b1;
    // A request landing in its own grant cycle starts a fresh dump rather than overflowing.
    pending_d = (pending_q & ~grant_mask) | dump_req_i;
    ovf_d     = (status_clr_i ? '0 : ovf_q) | (dump_req_i & pending_q & ~grant_mask);
    new_d     = status_clr_i ? '0 : new_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          ptr_d      = CHW'(wrap_inc(32'(grant), NUM_CH));
          sel_ch_d   = grant;
          sel_word_d = '0;
        end
      end
      StSel: ;
      StCap: begin
        out_valid_d = 1'b1;
        out_data_d  = bus.sel_data;
        out_ch_d    = sel_ch_q;
        out_word_d  = sel_word_q;
        out_last_d  = word_last;
      end
      StOut: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (word_last) new_d[sel_ch_q] = 1'b1;
          else           sel_word_d = sel_word_q + WW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pending_q   <= '0;
      new_q       <= '0;
      ovf_q       <= '0;
      ptr_q       <= '0;
      sel_ch_q    <= '0;
      sel_word_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
      out_word_q  <= '0;
      out_data_q  <= '0;
      accum_int_q <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      new_q       <= new_d;
      ovf_q       <= ovf_d;
      ptr_q       <= ptr_d;
      sel_ch_q    <= sel_ch_d;
      sel_word_q  <= sel_word_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
      out_word_q  <= out_word_d;
      out_data_q  <= out_data_d;
      accum_int_q <= |new_q;
    end
  end

  assign bus.sel_ch    = sel_ch_q;
  assign bus.sel_word  = sel_word_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_word  = out_word_q;
  assign bus.out_data  = out_data_q;
  assign status_new_o  = new_q;
  assign status_ovf_o  = ovf_q;
  assign accum_int_o   = accum_int_q;
  assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_namuru_dump_sched.sv
// Directed bench for namuru_dump_sched with a registered read-mux model and stream monitor.
module tb_namuru_dump_sched;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [11:0] dump_req = '0;
  logic        status_clr = 1'b0;
  logic [11:0] status_new, status_ovf;
  logic        accum_int, busy;
  int          checks = 0;
  int          errors = 0;
  logic [23:0] mon_q[$];

  namuru_dump_sched_if bus ();

  namuru_dump_sched #(
    .NUM_CH(12),
    .WORDS (6),
    .DW    (16)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .dump_req_i  (dump_req),
    .status_clr_i(status_clr),
    .status_new_o(status_new),
    .status_ovf_o(status_ovf),
    .accum_int_o (accum_int),
    .busy_o      (busy),
    .bus         (bus)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [15:0] mux_f(input logic [3:0] ch, input logic [2:0] w);
    return {4'h0, ch, 1'b0, w, 4'h5};
  endfunction

  function automatic logic [23:0] exp_entry(input logic [3:0] ch, input logic [2:0] w);
    return {(w == 3'd5), ch, w, mux_f(ch, w)};
  endfunction

  // Mux output follows the select one cycle later.
  always @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) bus.sel_data <= '0;
    else            bus.sel_data <= mux_f(bus.sel_ch, bus.sel_word);

  always @(posedge sys_clk)
    if (sys_rst_n && bus.out_valid && bus.out_ready)
      mon_q.push_back({bus.out_last, bus.out_ch, bus.out_word, bus.out_data});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_req(input logic [11:0] m);
    dump_req = m;
    @(negedge sys_clk);
    dump_req = '0;
  endtask

  task automatic pulse_clr();
    status_clr = 1'b1;
    @(negedge sys_clk);
    status_clr = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic wait_words(input int n, input int budget, input string tag);
    int cyc = 0;
    while (mon_q.size() < n && cyc < budget) begin
      @(negedge sys_clk);
      cyc++;
    end
    check(tag, mon_q.size(), n);
  endtask

  task automatic wait_word(input logic [2:0] w, input logic want_last, input int budget,
                           input string tag);
    int cyc = 0;
    while (!(bus.out_valid && bus.out_word == w && bus.out_last == want_last) && cyc < budget) begin
      @(negedge sys_clk);
      cyc++;
    end
    check(tag, bus.out_valid, 1'b1);
  endtask

  task automatic check_dump(input int base, input logic [3:0] ch, input string tag);
    for (int w = 0; w < 6; w++) begin
      if (base + w < mon_q.size()) check(tag, mon_q[base+w], exp_entry(ch, 3'(w)));
      else                         check(tag, 32'hDEAD, 32'(exp_entry(ch, 3'(w))));
    end
  endtask

  initial begin
    bus.out_ready = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("rst_valid", bus.out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_new", status_new, 12'h000);
    check("rst_sel", {bus.sel_ch, bus.sel_word}, 7'h00);
    check("rst_int", accum_int, 1'b0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // Single dump on ch 3: first word 4 negedges after the request edge, 3 cycles/word.
    pulse_req(12'h008);
    repeat (2) @(negedge sys_clk);
    check("t1_lat_lo", bus.out_valid, 1'b0);
    @(negedge sys_clk);
    for (int w = 0; w < 6; w++) begin
      check("t1_word", {bus.out_valid, bus.out_last, bus.out_ch, bus.out_word, bus.out_data},
            {1'b1, exp_entry(4'd3, 3'(w))});
      if (w < 5) repeat (3) @(negedge sys_clk);
    end
    @(negedge sys_clk);
    check("t1_new", status_new, 12'h008);
    check("t1_int_lag", accum_int, 1'b0);
    check("t1_idle", {busy, bus.out_valid}, 2'b00);
    @(negedge sys_clk);
    check("t1_int", accum_int, 1'b1);
    pulse_clr();
    check("t1_clr", {accum_int, status_new}, 13'h0);

    // All channels at once from ptr=0.
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    mon_q.delete();
    pulse_req(12'hFFF);
    wait_words(72, 400, "t2_count");
    for (int c = 0; c < 12; c++) check_dump(6 * c, 4'(c), "t2_order");
    repeat (3) @(negedge sys_clk);
    check("t2_new", status_new, 12'hFFF);
    check("t2_ovf", status_ovf, 12'h000);

    // Double request on ch 5 while ch 0 is being serviced.
    pulse_clr();
    mon_q.delete();
    pulse_req(12'h001);
    pulse_req(12'h020);
    pulse_req(12'h020);
    wait_words(12, 200, "t3_count");
    check_dump(0, 4'd0, "t3_ch0");
    check_dump(6, 4'd5, "t3_ch5");
    repeat (10) @(negedge sys_clk);
    check("t3_once", mon_q.size(), 12);
    check("t3_ovf", status_ovf, 12'h020);
    check("t3_new", status_new, 12'h021);

    // Backpressure at word 2 of ch 9; ch 1 requests pile up meanwhile.
    pulse_clr();
    mon_q.delete();
    pulse_req(12'h200);
    wait_word(3'd2, 1'b0, 30, "t4_reach");
    bus.out_ready = 1'b0;
    check("t4_hold0", {bus.out_valid, bus.out_ch, bus.out_word, bus.out_data},
          {1'b1, 4'd9, 3'd2, mux_f(4'd9, 3'd2)});
    pulse_req(12'h002);
    pulse_req(12'h002);
    repeat (18) @(negedge sys_clk);
    check("t4_hold20", {bus.out_valid, bus.out_ch, bus.out_word, bus.out_data},
          {1'b1, 4'd9, 3'd2, mux_f(4'd9, 3'd2)});
    check("t4_stall_cnt", mon_q.size(), 2);
    check("t4_ovf", status_ovf, 12'h002);
    bus.out_ready = 1'b1;
    wait_words(12, 200, "t4_count");
    check_dump(0, 4'd9, "t4_ch9");
    check_dump(6, 4'd1, "t4_ch1");
    repeat (3) @(negedge sys_clk);
    check("t4_new", status_new, 12'h202);

    // Clear coinciding with ch 7 final accept: the set wins, everything else clears.
    mon_q.delete();
    pulse_req(12'h080);
    wait_word(3'd5, 1'b1, 40, "t5_reach");
    status_clr = 1'b1;
    @(negedge sys_clk);
    status_clr = 1'b0;
    check("t5_new", status_new, 12'h080);
    check("t5_ovf", status_ovf, 12'h000);
    @(negedge sys_clk);
    check("t5_int", accum_int, 1'b1);
    check("t5_count", mon_q.size(), 6);

    // Reset during word 3 of ch 2, then a clean restart.
    mon_q.delete();
    pulse_req(12'h004);
    wait_word(3'd3, 1'b0, 40, "t6_reach");
    sys_rst_n = 1'b0;
    #1;
    check("t6_out", {bus.out_valid, bus.out_last, bus.out_ch, bus.out_word, bus.out_data}, 25'h0);
    check("t6_sel", {bus.sel_ch, bus.sel_word}, 7'h00);
    check("t6_stat", {busy, accum_int, status_new, status_ovf}, 26'h0);
    check("t6_partial", mon_q.size(), 3);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    mon_q.delete();
    pulse_req(12'h004);
    wait_words(6, 40, "t6_count");
    check_dump(0, 4'd2, "t6_restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
